// File: rtl/i2c_codec_cmd_seq.sv
// Codec register-write sequencer: replays a write table through the I2C controller,
// retries NACKed writes, and services runtime left/right volume updates.
module i2c_codec_cmd_seq #(
    parameter int         NUM_CMDS  = 9,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         MAX_RETRY = 3,
    parameter logic [6:0] LVOL_REG  = 7'h02,
    parameter logic [6:0] RVOL_REG  = 7'h03
) (
    input  logic                   clk_i2c,
    input  logic                   reset,
    input  logic [16*NUM_CMDS-1:0] cmd_table,
    input  logic                   restart,
    input  logic                   vol_update,
    input  logic [8:0]             vol_l,
    input  logic [8:0]             vol_r,
    output logic [23:0]            i2c_data,
    output logic                   i2c_go,
    input  logic                   i2c_end,
    input  logic [2:0]             i2c_nack,
    output logic                   busy,
    output logic                   config_done,
    output logic                   error,
    output logic [5:0]             err_idx
);
    // state | meaning
    // IDLE first cycle after reset   LOAD drive word + GO   WAIT await END
    // GAP  2-cycle GO-low rearm      NEXT advance source    DONE idle/serve   ERR retries exhausted
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, GAP, NEXT, DONE, ERR} state_t;
    typedef enum logic [1:0] {SRC_TABLE, SRC_VOL_L, SRC_VOL_R} src_t;

    state_t      state, state_n;
    src_t        src, src_n;
    logic [5:0]  idx, idx_n;
    logic [2:0]  retry, retry_n;
    logic        gap_cnt, gap_cnt_n;
    logic        vol_pend, vol_pend_n;
    logic        restart_pend, restart_pend_n;
    logic [8:0]  vol_l_q, vol_l_q_n, vol_r_q, vol_r_q_n;
    logic [23:0] data_n;
    logic        go_n, busy_n, done_n, error_n;
    logic [5:0]  err_idx_n;
    logic [15:0] entry;

    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_CMDS; i++)
            if (idx == 6'(i)) entry = cmd_table[16*i +: 16];
    end

    always_comb begin
        state_n        = state;
        src_n          = src;
        idx_n          = idx;
        retry_n        = retry;
        gap_cnt_n      = gap_cnt;
        vol_pend_n     = vol_pend;
        restart_pend_n = restart_pend;
        vol_l_q_n      = vol_l_q;
        vol_r_q_n      = vol_r_q;
        data_n         = i2c_data;
        go_n           = i2c_go;
        busy_n         = busy;
        done_n         = config_done;
        error_n        = error;
        err_idx_n      = err_idx;

        // Requests arriving outside DONE are parked until the sequencer is idle again.
        if (vol_update && state != DONE) vol_pend_n = 1'b1;
        if (restart && state != DONE && state != ERR) restart_pend_n = 1'b1;

        case (state)
            IDLE: begin
                src_n   = SRC_TABLE;
                idx_n   = '0;
                state_n = LOAD;
            end
            LOAD: begin
                case (src)
                    SRC_VOL_L: data_n = {DEV_ADDR, 1'b0, LVOL_REG, vol_l_q};
                    SRC_VOL_R: data_n = {DEV_ADDR, 1'b0, RVOL_REG, vol_r_q};
                    default:   data_n = {DEV_ADDR, 1'b0, entry};
                endcase
                go_n    = 1'b1;
                busy_n  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (i2c_end) begin
                    go_n = 1'b0;
                    if (i2c_nack == 3'b000) begin
                        retry_n = '0;
                        state_n = NEXT;
                    end else if (retry < 3'(MAX_RETRY)) begin
                        retry_n   = retry + 3'd1;
                        gap_cnt_n = 1'b0;
                        state_n   = GAP;
                    end else begin
                        retry_n   = '0;
                        error_n   = 1'b1;
                        err_idx_n = (src == SRC_TABLE) ? idx : 6'd63;
                        busy_n    = 1'b0;
                        state_n   = ERR;
                    end
                end
            end
            GAP: begin
                gap_cnt_n = 1'b1;
                if (gap_cnt) state_n = LOAD;
            end
            NEXT: begin
                gap_cnt_n = 1'b0;
                case (src)
                    SRC_VOL_L: begin
                        src_n   = SRC_VOL_R;
                        state_n = GAP;
                    end
                    SRC_VOL_R: begin
                        busy_n  = 1'b0;
                        state_n = DONE;
                    end
                    default: begin
                        if (idx == 6'(NUM_CMDS - 1)) begin
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = DONE;
                        end else begin
                            idx_n   = idx + 6'd1;
                            state_n = GAP;
                        end
                    end
                endcase
            end
            DONE, ERR: begin
                if (restart || restart_pend) begin
                    restart_pend_n = 1'b0;
                    vol_pend_n     = vol_pend || vol_update;
                    done_n         = 1'b0;
                    error_n        = 1'b0;
                    idx_n          = '0;
                    src_n          = SRC_TABLE;
                    state_n        = LOAD;
                end else if (state == DONE && (vol_pend || vol_update)) begin
                    vol_l_q_n  = vol_l;
                    vol_r_q_n  = vol_r;
                    vol_pend_n = 1'b0;
                    src_n      = SRC_VOL_L;
                    state_n    = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i2c or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            src          <= SRC_TABLE;
            idx          <= '0;
            retry        <= '0;
            gap_cnt      <= 1'b0;
            vol_pend     <= 1'b0;
            restart_pend <= 1'b0;
            vol_l_q      <= '0;
            vol_r_q      <= '0;
            i2c_data     <= '0;
            i2c_go       <= 1'b0;
            busy         <= 1'b0;
            config_done  <= 1'b0;
            error        <= 1'b0;
            err_idx      <= '0;
        end else begin
            state        <= state_n;
            src          <= src_n;
            idx          <= idx_n;
            retry        <= retry_n;
            gap_cnt      <= gap_cnt_n;
            vol_pend     <= vol_pend_n;
            restart_pend <= restart_pend_n;
            vol_l_q      <= vol_l_q_n;
            vol_r_q      <= vol_r_q_n;
            i2c_data     <= data_n;
            i2c_go       <= go_n;
            busy         <= busy_n;
            config_done  <= done_n;
            error        <= error_n;
            err_idx      <= err_idx_n;
        end
    end
endmodule

// File: tb/tb_i2c_codec_cmd_seq.sv
// Self-checking bench for i2c_codec_cmd_seq: behavioural I2C controller, a table/retry
// reference model, a vector table of NACK scenarios, corner-case sequences and random runs.
module tb_i2c_codec_cmd_seq;
    localparam int N    = 9;
    localparam int MAXR = 3;

    logic            clk_i2c = 1'b0;
    logic            reset;
    logic [16*N-1:0] cmd_table;
    logic            restart, vol_update;
    logic [8:0]      vol_l, vol_r;
    logic [23:0]     i2c_data;
    logic            i2c_go, i2c_end;
    logic [2:0]      i2c_nack;
    logic            busy, config_done, error;
    logic [5:0]      err_idx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [23:0] sent_q[$];
    logic [23:0] exp_q[$];
    int          rise_q[$];
    int          end_q[$];
    int          nack_target;
    int          nack_left;
    logic        exp_err;
    logic [5:0]  exp_eidx;
    logic [15:0] tbl[N];

    typedef struct {
        int         nidx;
        int         ncnt;
        logic       done;
        logic       err;
        logic [5:0] eidx;
        int         writes;
    } vec_t;
    vec_t vecs[5];

    i2c_codec_cmd_seq #(.NUM_CMDS(N), .MAX_RETRY(MAXR)) dut (
        .clk_i2c(clk_i2c), .reset(reset), .cmd_table(cmd_table), .restart(restart),
        .vol_update(vol_update), .vol_l(vol_l), .vol_r(vol_r), .i2c_data(i2c_data),
        .i2c_go(i2c_go), .i2c_end(i2c_end), .i2c_nack(i2c_nack), .busy(busy),
        .config_done(config_done), .error(error), .err_idx(err_idx)
    );

    always #50 clk_i2c = ~clk_i2c;
    always @(posedge clk_i2c) cyc <= cyc + 1;

    // Controller model: END one cycle, 20 cycles after GO is seen; NACKs the target word.
    initial begin : ctrl
        logic go_prev;
        int   cnt;
        i2c_end = 1'b0; i2c_nack = 3'b000; go_prev = 1'b0; cnt = 0;
        forever begin
            @(posedge clk_i2c); #1;
            if (i2c_go && !go_prev) rise_q.push_back(cyc);
            go_prev = i2c_go;
            if (i2c_end) begin
                i2c_end = 1'b0; i2c_nack = 3'b000; cnt = 0;
            end else if (i2c_go) begin
                cnt++;
                if (cnt == 20) begin
                    sent_q.push_back(i2c_data);
                    end_q.push_back(cyc);
                    if (nack_target >= 0 && int'(i2c_data) == nack_target && nack_left > 0) begin
                        i2c_nack  = 3'b010;
                        nack_left = nack_left - 1;
                    end
                    i2c_end = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    function automatic logic [23:0] word(int i);
        return {7'h1A, 1'b0, tbl[i]};
    endfunction

    function automatic logic [23:0] vol_word(logic [6:0] r, logic [8:0] v);
        return {7'h1A, 1'b0, r, v};
    endfunction

    // Expected write stream: each entry is sent until it ACKs, at most MAXR+1 times.
    function automatic void model(input int nt, input int nc);
        int left;
        logic [23:0] w;
        exp_q.delete(); exp_err = 1'b0; exp_eidx = '0; left = nc;
        for (int i = 0; i < N; i++) begin
            w = word(i);
            for (int a = 0; a <= MAXR; a++) begin
                exp_q.push_back(w);
                if (int'(w) == nt && left > 0) left--;
                else break;
                if (a == MAXR) begin
                    exp_err = 1'b1; exp_eidx = 6'(i);
                    return;
                end
            end
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_log(string name);
        check({name, " writes"}, 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            check($sformatf("%s write %0d", name, i), 32'(sent_q[i]), 32'(exp_q[i]));
    endtask

    task automatic apply_table();
        for (int i = 0; i < N; i++) cmd_table[16*i +: 16] = tbl[i];
    endtask

    task automatic tick();
        @(posedge clk_i2c); #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1; tick(); restart = 1'b0;
    endtask

    task automatic pulse_vol();
        vol_update = 1'b1; tick(); vol_update = 1'b0;
    endtask

    task automatic wait_run(string name);
        int n;
        n = 0;
        while (!busy && n < 50) begin tick(); n++; end
        check({name, " busy rises"}, 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 3000) begin tick(); n++; end
        check({name, " busy falls"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_word(string name, logic [23:0] w);
        int n;
        n = 0;
        while (!(i2c_go && i2c_data == w) && n < 2000) begin tick(); n++; end
        check({name, " word reached"}, 32'(i2c_go && i2c_data == w), 32'd1);
    endtask

    task automatic set_nack(int idx, int cnt);
        if (idx >= 0) nack_target = int'(word(idx));
        else nack_target = -1;
        nack_left = cnt;
    endtask

    initial begin
        int ngap, rgap, nidx, ncnt;
        tbl[0] = 16'h1E00; tbl[1] = 16'h0C00; tbl[2] = 16'h0E4A; tbl[3] = 16'h1000;
        tbl[4] = 16'h0017; tbl[5] = 16'h0217; tbl[6] = 16'h0812; tbl[7] = 16'h1201;
        tbl[8] = 16'h0A06;
        apply_table();
        vecs[0] = '{nidx: -1, ncnt: 0, done: 1'b1, err: 1'b0, eidx: 6'd0, writes: 9};
        vecs[1] = '{nidx: 3,  ncnt: 2, done: 1'b1, err: 1'b0, eidx: 6'd0, writes: 11};
        vecs[2] = '{nidx: 5,  ncnt: 4, done: 1'b0, err: 1'b1, eidx: 6'd5, writes: 9};
        vecs[3] = '{nidx: 0,  ncnt: 3, done: 1'b1, err: 1'b0, eidx: 6'd0, writes: 12};
        vecs[4] = '{nidx: 8,  ncnt: 6, done: 1'b0, err: 1'b1, eidx: 6'd8, writes: 12};
        set_nack(-1, 0);
        restart = 1'b0; vol_update = 1'b0; vol_l = '0; vol_r = '0;
        reset = 1'b1;
        repeat (3) tick();
        check("reset go", 32'(i2c_go), 32'd0);
        check("reset data", 32'(i2c_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(config_done), 32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset err_idx", 32'(err_idx), 32'd0);

        sent_q.delete();
        reset = 1'b0;
        tick();
        check("go 1 cycle after release", 32'(i2c_go), 32'd0);
        tick();
        check("go 2 cycles after release", 32'(i2c_go), 32'd1);
        check("first word", 32'(i2c_data), 32'h341E00);
        wait_run("boot");
        model(-1, 0);
        check_log("boot");
        check("boot done", 32'(config_done), 32'd1);
        check("boot error", 32'(error), 32'd0);

        for (int v = 0; v < 5; v++) begin
            set_nack(vecs[v].nidx, vecs[v].ncnt);
            model(nack_target, vecs[v].ncnt);
            sent_q.delete(); rise_q.delete(); end_q.delete();
            pulse_restart();
            wait_run($sformatf("vec%0d", v));
            check_log($sformatf("vec%0d", v));
            check($sformatf("vec%0d count", v), 32'(sent_q.size()), 32'(vecs[v].writes));
            check($sformatf("vec%0d done", v), 32'(config_done), 32'(vecs[v].done));
            check($sformatf("vec%0d error", v), 32'(error), 32'(vecs[v].err));
            if (vecs[v].err) check($sformatf("vec%0d err_idx", v), 32'(err_idx), 32'(vecs[v].eidx));
            if (v == 1 && rise_q.size() > 4 && end_q.size() > 3) begin
                ngap = rise_q[1] - end_q[0];
                rgap = rise_q[4] - end_q[3];
                check("normal gap exceeds retry gap by one", 32'(ngap - rgap), 32'd1);
            end
        end

        // vol_update in ERR is parked and served after the restarted table completes
        vol_l = 9'h021; vol_r = 9'h042;
        pulse_vol();
        repeat (3) tick();
        check("err ignores vol busy", 32'(busy), 32'd0);
        check("err ignores vol error", 32'(error), 32'd1);
        set_nack(-1, 0); model(-1, 0);
        exp_q.push_back(vol_word(7'h02, 9'h021));
        exp_q.push_back(vol_word(7'h03, 9'h042));
        sent_q.delete();
        pulse_restart();
        wait_run("err vol table");
        check("err vol table done", 32'(config_done), 32'd1);
        wait_run("err vol writes");
        check_log("err vol");

        vol_l = 9'h079; vol_r = 9'h070;
        sent_q.delete(); exp_q.delete();
        exp_q.push_back(24'h340479); exp_q.push_back(24'h340670);
        pulse_vol();
        wait_run("done vol");
        check_log("done vol");
        check("done vol keeps done", 32'(config_done), 32'd1);

        // volume request mid-table, then values change before the table ends
        vol_l = 9'h011; vol_r = 9'h022;
        sent_q.delete();
        pulse_restart();
        wait_word("vol mid entry2", word(2));
        pulse_vol();
        wait_word("vol mid entry6", word(6));
        vol_l = 9'h055; vol_r = 9'h066;
        wait_run("vol mid table");
        check("vol mid table only", 32'(sent_q.size()), 32'd9);
        check("vol mid done", 32'(config_done), 32'd1);
        wait_run("vol mid writes");
        model(-1, 0);
        exp_q.push_back(24'h340455); exp_q.push_back(24'h340666);
        check_log("vol mid");

        // restart while busy finishes the current run, then reruns once
        sent_q.delete();
        pulse_restart();
        wait_word("busy restart entry4", word(4));
        pulse_restart();
        wait_run("busy restart run1");
        check("busy restart run1 writes", 32'(sent_q.size()), 32'd9);
        wait_run("busy restart run2");
        check("busy restart total writes", 32'(sent_q.size()), 32'd18);
        check("busy restart done", 32'(config_done), 32'd1);

        // reset during WAIT at entry 4
        pulse_restart();
        wait_word("reset mid entry4", word(4));
        #20 reset = 1'b1;
        #1;
        check("reset mid go drops", 32'(i2c_go), 32'd0);
        check("reset mid busy drops", 32'(busy), 32'd0);
        tick();
        sent_q.delete();
        reset = 1'b0;
        wait_run("reset mid rerun");
        model(-1, 0);
        check_log("reset mid rerun");
        check("reset mid done", 32'(config_done), 32'd1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) tbl[i] = {7'(i + 1), 9'($urandom_range(0, 511))};
            apply_table();
            nidx = int'($urandom_range(0, N - 1));
            ncnt = int'($urandom_range(0, 5));
            set_nack(nidx, ncnt);
            model(nack_target, ncnt);
            sent_q.delete();
            pulse_restart();
            wait_run($sformatf("rand%0d", r));
            check_log($sformatf("rand%0d", r));
            check($sformatf("rand%0d error", r), 32'(error), 32'(exp_err));
            check($sformatf("rand%0d done", r), 32'(config_done), 32'(!exp_err));
            if (exp_err) begin
                check($sformatf("rand%0d err_idx", r), 32'(err_idx), 32'(exp_eidx));
            end else begin
                vol_l = 9'($urandom_range(0, 511)); vol_r = 9'($urandom_range(0, 511));
                exp_q.delete(); sent_q.delete();
                exp_q.push_back(vol_word(7'h02, vol_l));
                exp_q.push_back(vol_word(7'h03, vol_r));
                pulse_vol();
                wait_run($sformatf("rand%0d vol", r));
                check_log($sformatf("rand%0d vol", r));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
